// File: rtl/n64_read_response.sv
`timescale 1ns/1ps
// N64 controller response decoder: measures low-phase widths on a synchronized data line and assembles NUM_BITS data bits LSB first.
// Latency: 2-clock synchronizer, then response/valid one clock after the stop-bit rise; no backpressure (valid is a single-cycle pulse).
module n64_read_response #(
    parameter int THRESHOLD = 200,
    parameter int MIN_LOW   = 20,
    parameter int TIMEOUT   = 800,
    parameter int NUM_BITS  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                data_in,
    input  logic                en,
    output logic [NUM_BITS-1:0] response,
    output logic                valid,
    output logic                busy,
    output logic                error
);

    localparam int CMAX = (TIMEOUT > THRESHOLD) ? TIMEOUT : THRESHOLD;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(NUM_BITS + 1);

    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] MIN_C    = CW'(MIN_LOW);
    localparam logic [CW-1:0] THR_C    = CW'(THRESHOLD);
    localparam logic [IW-1:0] STOP_IDX = IW'(NUM_BITS);

    typedef enum logic [1:0] {IDLE, ARMED, LOW, HIGH} state_t;

    state_t              state;
    state_t              nxt;
    logic                sync_q1;
    logic                line_s;
    logic [CW-1:0]       low_cnt;
    logic [CW-1:0]       high_cnt;
    logic [IW-1:0]       bit_idx;
    logic [NUM_BITS-1:0] shreg;
    logic                abort;
    logic                frame_done;
    logic                bit_val;

    // Line idles high, so the synchronizer resets to 1 to avoid a false falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            line_s  <= 1'b1;
        end else begin
            sync_q1 <= data_in;
            line_s  <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt        = state;
        abort      = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE:  if (en) nxt = ARMED;
            ARMED: if (!line_s) nxt = LOW;
            LOW: begin
                if (!line_s) begin
                    if (low_cnt >= TO_LAST) begin
                        abort = 1'b1;
                        nxt   = IDLE;
                    end
                end else if (low_cnt < MIN_C) begin
                    abort = 1'b1;
                    nxt   = IDLE;
                end else if (bit_idx == STOP_IDX) begin
                    frame_done = 1'b1;
                    nxt        = IDLE;
                end else begin
                    nxt = HIGH;
                end
            end
            HIGH: begin
                if (!line_s) begin
                    nxt = LOW;
                end else if (high_cnt >= TO_LAST) begin
                    abort = 1'b1;
                    nxt   = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    assign bit_val = (low_cnt < THR_C);

    // Counters saturate one short of TIMEOUT; the FSM aborts on the sample that would reach it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt  <= '0;
            high_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        bit_idx <= '0;
                        shreg   <= '0;
                    end
                end
                ARMED: begin
                    if (!line_s) low_cnt <= CW'(1);
                end
                LOW: begin
                    if (!line_s) begin
                        if (low_cnt < TO_LAST) low_cnt <= low_cnt + 1'b1;
                    end else if (low_cnt >= MIN_C && bit_idx != STOP_IDX) begin
                        shreg    <= shreg | ({{(NUM_BITS-1){1'b0}}, bit_val} << bit_idx);
                        high_cnt <= CW'(1);
                    end
                end
                HIGH: begin
                    if (!line_s) begin
                        low_cnt <= CW'(1);
                        bit_idx <= bit_idx + 1'b1;
                    end else if (high_cnt < TO_LAST) begin
                        high_cnt <= high_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            response <= '0;
            valid    <= 1'b0;
            error    <= 1'b0;
        end else begin
            if (frame_done) response <= shreg;
            valid <= frame_done;
            error <= abort;
        end
    end

endmodule

// File: tb/tb_n64_read_response.sv
`timescale 1ns/1ps
// Scoreboard bench for n64_read_response: drives pulse-width frames, checks decoded words, aborts and reset behaviour.
module tb_n64_read_response;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_in;
    logic        en;
    logic [31:0] response;
    logic        valid;
    logic        busy;
    logic        error;

    int          checks = 0;
    int          errors = 0;
    int          n_valid = 0;
    int          n_err = 0;
    int          v0, e0, lat;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    n64_read_response dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .en       (en),
        .response (response),
        .valid    (valid),
        .busy     (busy),
        .error    (error)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid && error) chk("valid_error_overlap", 32'd1, 32'd0);
        if (error) n_err++;
        if (valid) begin
            n_valid++;
            if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
            else                   chk("response", response, exp_q.pop_front());
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pulse(input int lo, input int hi);
        data_in = 1'b0;
        wait_n(lo);
        data_in = 1'b1;
        wait_n(hi);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_pulse(100, 300);
        else   send_pulse(300, 100);
    endtask

    task automatic send_bits(input logic [31:0] w, input int first, input int last);
        for (int i = first; i <= last; i++) send_bit(w[i]);
    endtask

    task automatic stop_bit();
        send_pulse(100, 20);
    endtask

    task automatic arm();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        data_in = 1'b1;
        en      = 1'b0;
        wait_n(3);
        chk("rst_response", response, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_error", {31'b0, error}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        wait_n(3);

        // Line activity without en must be ignored.
        e0 = n_err;
        send_pulse(100, 50);
        chk("noarm_busy", {31'b0, busy}, 32'd0);
        chk("noarm_err", n_err - e0, 32'd0);

        // Word 0x0000_8001.
        arm();
        chk("armed_busy", {31'b0, busy}, 32'd1);
        exp_q.push_back(32'h0000_8001);
        v0 = n_valid;
        send_bits(32'h0000_8001, 0, 31);
        stop_bit();
        wait_n(10);
        chk("w8001_valid_cnt", n_valid - v0, 32'd1);
        chk("w8001_busy", {31'b0, busy}, 32'd0);

        // Threshold and MIN_LOW boundaries: 199->1, 200->0, 20->1; en mid-frame is ignored.
        arm();
        exp_q.push_back(32'h0000_0005);
        v0 = n_valid;
        send_pulse(199, 300);
        send_pulse(200, 100);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        send_pulse(20, 300);
        send_bits(32'h0, 3, 31);
        stop_bit();
        wait_n(10);
        chk("thr_valid_cnt", n_valid - v0, 32'd1);
        chk("thr_busy", {31'b0, busy}, 32'd0);

        // Low of 799 is a valid 0; low of 800 during bit 5 aborts.
        arm();
        e0 = n_err;
        v0 = n_valid;
        send_bits(32'hFFFF_FFFF, 0, 3);
        send_pulse(799, 100);
        chk("low799_busy", {31'b0, busy}, 32'd1);
        chk("low799_err", n_err - e0, 32'd0);
        data_in = 1'b0;
        wait_n(800);
        data_in = 1'b1;
        wait_n(10);
        chk("lowto_err", n_err - e0, 32'd1);
        chk("lowto_valid", n_valid - v0, 32'd0);
        chk("lowto_busy", {31'b0, busy}, 32'd0);
        chk("lowto_resp", response, 32'h0000_0005);

        // Short glitches in ARMED: 10 and 19 clocks.
        arm();
        e0 = n_err;
        send_pulse(10, 50);
        chk("glitch10_err", n_err - e0, 32'd1);
        chk("glitch10_busy", {31'b0, busy}, 32'd0);
        arm();
        e0 = n_err;
        send_pulse(19, 50);
        chk("glitch19_err", n_err - e0, 32'd1);
        chk("glitch19_busy", {31'b0, busy}, 32'd0);

        // Line stays high after bit 17: 2 sync clocks plus 800 high samples.
        arm();
        e0 = n_err;
        send_bits(32'hAAAA_AAAA, 0, 16);
        data_in = 1'b0;
        wait_n(100);
        data_in = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!error && lat < 1000);
        chk("highto_latency", lat, 32'd802);
        wait_n(3);
        chk("highto_err", n_err - e0, 32'd1);
        chk("highto_busy", {31'b0, busy}, 32'd0);
        chk("highto_resp", response, 32'h0000_0005);

        // Reset during bit 12 low phase.
        arm();
        send_bits(32'hFFFF_FFFF, 0, 11);
        data_in = 1'b0;
        wait_n(50);
        v0 = n_valid;
        e0 = n_err;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_resp", response, 32'h0);
        wait_n(5);
        data_in = 1'b1;
        wait_n(3);
        rst_n = 1'b1;
        wait_n(5);
        chk("midrst_valid_cnt", n_valid - v0, 32'd0);
        chk("midrst_err_cnt", n_err - e0, 32'd0);
        send_pulse(100, 50);
        chk("postrst_noarm_busy", {31'b0, busy}, 32'd0);

        arm();
        exp_q.push_back(32'hFFFF_FFFF);
        v0 = n_valid;
        send_bits(32'hFFFF_FFFF, 0, 31);
        stop_bit();
        wait_n(10);
        chk("ffff_valid_cnt", n_valid - v0, 32'd1);
        chk("ffff_busy", {31'b0, busy}, 32'd0);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
